stream_muxer: RTL and testbench
===============================

Name: stream_muxer

Overview:
- Transmit-side counterpart of the stream splitter: merges the video and misc byte channels into one framed byte stream.
- Each channel is buffered in its own FIFO. Bytes are emitted as packets: SYNC, TYPE, LEN, then LEN payload bytes.
- Sits ahead of the serial/stream output. Its output must be parseable by the splitter.

Parameters:
- FIFO_DEPTH, 64: bytes per channel FIFO; power of two, at least PKT_LEN.
- PKT_LEN, 32: maximum payload bytes per packet; range 1..255.
- TIMEOUT, 64: idle cycles after which a non-empty channel may send a short packet.
- SYNC_BYTE, 8'hA5: first byte of every packet.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- vid_in  in  8  video byte.
- vid_in_en  in  1  vid_in valid; push-only, no backpressure.
- misc_in  in  8  misc byte.
- misc_in_en  in  1  misc_in valid; push-only.
- stream_data  out  8  framed output byte.
- stream_valid  out  1  stream_data valid.
- stream_ready  in  1  downstream accepts the byte; a transfer happens when valid and ready are both 1.
- vid_ovf  out  1  sticky: a video byte was dropped.
- misc_ovf  out  1  sticky: a misc byte was dropped.

Behaviour:
- Reset: stream_data=0, stream_valid=0, vid_ovf=0, misc_ovf=0, both FIFOs empty, timers=0, state=IDLE, round-robin pointer=video.
- Reset mid-packet truncates the packet: no further bytes; stream_valid=0 on the cycle after rst.
- FIFO write: *_in_en=1 with FIFO not full stores the byte. If the FIFO is full, the byte is dropped and *_ovf is set. The ovf flag clears only on rst.
- A write in the same cycle as a read of a full FIFO is still dropped; the full check uses the pre-edge count.
- Channel eligibility (in IDLE): count ≥ PKT_LEN, OR (count > 0 AND timer ≥ TIMEOUT).
- Timer: cleared on each write to that channel and at packet grant. Otherwise increments while count > 0, saturating at TIMEOUT.
- Arbitration: if one channel is eligible, it is granted. If both, the channel not served last is granted; after reset, video wins.
- At grant, LEN = min(count, PKT_LEN) is latched. Bytes arriving during the packet wait for a later packet.
- State machine: IDLE → SYNC → TYPE → LEN → PAYLOAD → IDLE.
  - In each non-IDLE state the byte is held (data and valid stable) until the transfer; the state advances on the transfer.
  - TYPE byte: 8'h01 for video, 8'h02 for misc.
  - PAYLOAD pops one FIFO byte per transfer and returns to IDLE after LEN transfers.
  - If stream_ready=1 throughout, a packet occupies 3+LEN consecutive valid cycles. IDLE adds one dead cycle between packets.
- Latency: eligibility in IDLE at edge N gives the SYNC byte valid in the cycle after edge N.
- stream_valid=0 in IDLE. stream_valid never drops mid-packet while stream_ready is low.
- Payload bytes go out in FIFO (arrival) order.
- FIFO read is first-word-fall-through, so the payload byte is valid in the same cycle as the pop.

Optional Feature:
- Macro: STREAM_MUXER_CHECKSUM_EN.
- Defined: a CSUM state follows PAYLOAD and sends the XOR of the TYPE, LEN and all payload bytes; packet length is 4+LEN.
- Undefined: no CSUM state; packet length is 3+LEN; no checksum logic is built.

Decomposition:
- Shared package mux_pkg holds:
  - TYPE_VID=8'h01 and TYPE_MISC=8'h02, also used by the splitter.
  - The state enum (IDLE, SYNC, TYPE, LEN, PAYLOAD, CSUM).
  - Default SYNC_BYTE.
- Sub-module byte_fifo: synchronous FWFT FIFO with count output, instantiated twice.

Test Plan:
- 32 video bytes 0x00..0x1F on consecutive cycles, stream_ready=1 → A5 01 20 00..1F back-to-back, starting the cycle after the 32nd write is seen in IDLE.
- 3 misc bytes 0x10,0x11,0x12, then silence → after 64 idle cycles: A5 02 03 10 11 12.
- Both FIFOs reach 32 in the same cycle → full video packet first, one IDLE cycle, then full misc packet. Repeat → misc goes first.
- stream_ready toggles 1,0,0,1… during a packet → each byte held stable while ready=0; no byte lost or duplicated; order intact.
- 65 video writes with stream_ready=0 → 65th byte dropped; vid_ovf=1 and stays 1 until rst.
- rst asserted mid-PAYLOAD → stream_valid=0 the next cycle; FIFOs empty; next packet starts with A5.
- With STREAM_MUXER_CHECKSUM_EN defined: misc bytes 0x10,0x11,0x12 → trailing byte = 02^03^10^11^12 = 8'h12.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the stream muxer and the stream splitter:
// packet type codes, default sync byte, FSM state and channel encodings.
package mux_pkg;

  localparam logic [7:0] TYPE_VID          = 8'h01;
  localparam logic [7:0] TYPE_MISC         = 8'h02;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StType,
    StLen,
    StPayload,
    StCsum
  } mux_state_e;

  typedef enum logic {
    ChVid,
    ChMisc
  } chan_e;

  function automatic logic [7:0] type_byte(input chan_e ch);
    return (ch == ChMisc) ? TYPE_MISC : TYPE_VID;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
// DEPTH must be a power of two (pointers wrap naturally).
module byte_fifo #(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AddrW = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  output logic [CntW-1:0] count,
  output logic            full
);

  logic [7:0]       mem_q [DEPTH];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             empty;
  logic             wr_ok, rd_ok;

  // Full/empty come from the registered count, so a write to a full FIFO is
  // dropped even if a read frees a slot in the same cycle.
  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CntW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AddrW'(1);
      if (rd_ok) rptr_q <= rptr_q + AddrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/stream_muxer.sv
// Merges the video and misc byte channels into SYNC/TYPE/LEN/payload packets.
// Optional trailing XOR checksum byte when STREAM_MUXER_CHECKSUM_EN is defined.
module stream_muxer
  import mux_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned PKT_LEN    = 32,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vid_in,
  input  logic       vid_in_en,
  input  logic [7:0] misc_in,
  input  logic       misc_in_en,
  output logic [7:0] stream_data,
  output logic       stream_valid,
  input  logic       stream_ready,
  output logic       vid_ovf,
  output logic       misc_ovf
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] vid_count, misc_count;
  logic [7:0]      vid_head, misc_head;
  logic            vid_full, misc_full;
  logic            vid_rd, misc_rd;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_vid_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vid_in_en),
    .wr_data (vid_in),
    .rd_en   (vid_rd),
    .rd_data (vid_head),
    .count   (vid_count),
    .full    (vid_full)
  );

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_misc_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (misc_in_en),
    .wr_data (misc_in),
    .rd_en   (misc_rd),
    .rd_data (misc_head),
    .count   (misc_count),
    .full    (misc_full)
  );

  // Sticky overflow flags
  logic vid_ovf_q, misc_ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_ovf_q  <= 1'b0;
      misc_ovf_q <= 1'b0;
    end else begin
      if (vid_in_en && vid_full)   vid_ovf_q  <= 1'b1;
      if (misc_in_en && misc_full) misc_ovf_q <= 1'b1;
    end
  end

  assign vid_ovf  = vid_ovf_q;
  assign misc_ovf = misc_ovf_q;

  // Idle timers and eligibility
  logic [TmrW-1:0] vid_tmr_q, misc_tmr_q;
  logic            grant_vid, grant_misc;
  logic            vid_elig, misc_elig;

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_tmr_q <= '0;
    end else if (vid_in_en || grant_vid) begin
      vid_tmr_q <= '0;
    end else if (vid_count != '0 && 32'(vid_tmr_q) < TIMEOUT) begin
      vid_tmr_q <= vid_tmr_q + TmrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misc_tmr_q <= '0;
    end else if (misc_in_en || grant_misc) begin
      misc_tmr_q <= '0;
    end else if (misc_count != '0 && 32'(misc_tmr_q) < TIMEOUT) begin
      misc_tmr_q <= misc_tmr_q + TmrW'(1);
    end
  end

  assign vid_elig  = (32'(vid_count) >= PKT_LEN) ||
                     ((vid_count != '0) && (32'(vid_tmr_q) >= TIMEOUT));
  assign misc_elig = (32'(misc_count) >= PKT_LEN) ||
                     ((misc_count != '0) && (32'(misc_tmr_q) >= TIMEOUT));

  // Packet FSM
  mux_state_e state_q, state_d;
  chan_e      ch_q, ch_d;
  chan_e      ptr_q, ptr_d;   // channel preferred on the next tie
  logic [7:0] len_q, len_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] head_sel;
  logic [7:0] grant_len;
  chan_e      grant_ch;
  logic [CntW-1:0] grant_count;
`ifdef STREAM_MUXER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  assign head_sel    = (ch_q == ChVid) ? vid_head : misc_head;
  assign grant_ch    = (vid_elig && (!misc_elig || ptr_q == ChVid)) ? ChVid : ChMisc;
  assign grant_count = (grant_ch == ChVid) ? vid_count : misc_count;
  assign grant_len   = (32'(grant_count) >= PKT_LEN) ? 8'(PKT_LEN) : 8'(grant_count);

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    ptr_d        = ptr_q;
    len_d        = len_q;
    rem_d        = rem_q;
    grant_vid    = 1'b0;
    grant_misc   = 1'b0;
    vid_rd       = 1'b0;
    misc_rd      = 1'b0;
    stream_valid = 1'b0;
    stream_data  = 8'h00;
`ifdef STREAM_MUXER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (vid_elig || misc_elig) begin
          grant_vid  = (grant_ch == ChVid);
          grant_misc = (grant_ch == ChMisc);
          ch_d       = grant_ch;
          ptr_d      = (grant_ch == ChVid) ? ChMisc : ChVid;
          len_d      = grant_len;
          rem_d      = grant_len;
          state_d    = StSync;
`ifdef STREAM_MUXER_CHECKSUM_EN
          csum_d     = type_byte(grant_ch) ^ grant_len;
`endif
        end
      end
      StSync: begin
        stream_valid = 1'b1;
        stream_data  = SYNC_BYTE;
        if (stream_ready) state_d = StType;
      end
      StType: begin
        stream_valid = 1'b1;
        stream_data  = type_byte(ch_q);
        if (stream_ready) state_d = StLen;
      end
      StLen: begin
        stream_valid = 1'b1;
        stream_data  = len_q;
        if (stream_ready) state_d = StPayload;
      end
      StPayload: begin
        stream_valid = 1'b1;
        stream_data  = head_sel;
        if (stream_ready) begin
          vid_rd  = (ch_q == ChVid);
          misc_rd = (ch_q == ChMisc);
          rem_d   = rem_q - 8'd1;
`ifdef STREAM_MUXER_CHECKSUM_EN
          csum_d  = csum_q ^ head_sel;
          if (rem_q == 8'd1) state_d = StCsum;
`else
          if (rem_q == 8'd1) state_d = StIdle;
`endif
        end
      end
`ifdef STREAM_MUXER_CHECKSUM_EN
      StCsum: begin
        stream_valid = 1'b1;
        stream_data  = csum_q;
        if (stream_ready) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ch_q    <= ChVid;
      ptr_q   <= ChVid;
      len_q   <= 8'h00;
      rem_q   <= 8'h00;
`ifdef STREAM_MUXER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
`ifdef STREAM_MUXER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_stream_muxer.sv
// Scoreboard bench for stream_muxer: stimulus pushes expected bytes, a
// negedge monitor pops and compares every accepted output byte.
module tb_stream_muxer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] vid_in = 8'h00;
  logic       vid_in_en = 1'b0;
  logic [7:0] misc_in = 8'h00;
  logic       misc_in_en = 1'b0;
  logic [7:0] stream_data;
  logic       stream_valid;
  logic       stream_ready = 1'b1;
  logic       vid_ovf;
  logic       misc_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  stream_muxer dut (
    .clk          (clk),
    .rst          (rst),
    .vid_in       (vid_in),
    .vid_in_en    (vid_in_en),
    .misc_in      (misc_in),
    .misc_in_en   (misc_in_en),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .vid_ovf      (vid_ovf),
    .misc_ovf     (misc_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [7:0] typ, input int len, input logic [7:0] first);
    logic [7:0] c;
    logic [7:0] b;
    exp_q.push_back(8'hA5);
    exp_q.push_back(typ);
    exp_q.push_back(8'(len));
    c = typ ^ 8'(len);
    for (int i = 0; i < len; i++) begin
      b = first + 8'(i);
      exp_q.push_back(b);
      c = c ^ b;
    end
`ifdef STREAM_MUXER_CHECKSUM_EN
    exp_q.push_back(c);
`endif
  endtask

  task automatic wr(input bit v, input bit m, input int n,
                    input logic [7:0] vfirst, input logic [7:0] mfirst);
    for (int i = 0; i < n; i++) begin
      vid_in_en  = v;
      vid_in     = vfirst + 8'(i);
      misc_in_en = m;
      misc_in    = mfirst + 8'(i);
      tick();
    end
    vid_in_en  = 1'b0;
    misc_in_en = 1'b0;
  endtask

  task automatic drain(input int budget, input bit toggle, input string name);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      if (toggle) stream_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      tick();
      cyc++;
    end
    stream_ready = 1'b1;
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) tick();
  endtask

  // Monitor: compares accepted bytes and checks holds while ready is low
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (hold_pend)
        check("held byte", 32'({stream_valid, stream_data}), 32'({1'b1, hold_data}));
      if (stream_valid && stream_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected byte: got %0h, expected none", stream_data);
        end else begin
          e = exp_q.pop_front();
          check("stream byte", 32'(stream_data), 32'(e));
        end
      end
      hold_pend = stream_valid && !stream_ready;
      hold_data = stream_data;
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    int early;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset valid", 32'(stream_valid), 32'd0);
    check("reset data", 32'(stream_data), 32'd0);
    check("reset vid_ovf", 32'(vid_ovf), 32'd0);
    check("reset misc_ovf", 32'(misc_ovf), 32'd0);

    // Full video packet, latency from 32nd write
    push_pkt(8'h01, 32, 8'h00);
    wr(1'b1, 1'b0, 32, 8'h00, 8'h00);
    check("valid before grant", 32'(stream_valid), 32'd0);
    tick();
    check("sync latency", 32'({stream_valid, stream_data}), 32'({1'b1, 8'hA5}));
    drain(200, 1'b0, "video packet drained");

    // Short misc packet after timeout
    push_pkt(8'h02, 3, 8'h10);
    wr(1'b0, 1'b1, 3, 8'h00, 8'h10);
    early = 0;
    repeat (64) begin
      tick();
      if (stream_valid) early++;
    end
    check("no early short packet", 32'(early), 32'd0);
    drain(50, 1'b0, "short misc packet drained");

    // Both full together; video preferred (misc served last)
    push_pkt(8'h01, 32, 8'h40);
    push_pkt(8'h02, 32, 8'h80);
    wr(1'b1, 1'b1, 32, 8'h40, 8'h80);
    drain(300, 1'b0, "tie video-first drained");

    // Backpressure pattern 1,0,0,1
    push_pkt(8'h01, 32, 8'hC0);
    wr(1'b1, 1'b0, 32, 8'hC0, 8'h00);
    drain(400, 1'b1, "backpressure packet drained");

    // Overflow: 65 writes with ready low
    stream_ready = 1'b0;
    wr(1'b1, 1'b0, 64, 8'h00, 8'h00);
    check("no ovf at 64", 32'(vid_ovf), 32'd0);
    wr(1'b1, 1'b0, 1, 8'h40, 8'h00);
    check("ovf at 65", 32'(vid_ovf), 32'd1);
    check("misc ovf clear", 32'(misc_ovf), 32'd0);
    push_pkt(8'h01, 32, 8'h00);
    push_pkt(8'h01, 32, 8'h20);
    stream_ready = 1'b1;
    drain(300, 1'b0, "overflow packets drained");
    check("ovf sticky", 32'(vid_ovf), 32'd1);

    // Tie again after video served last: misc first
    push_pkt(8'h02, 32, 8'hA0);
    push_pkt(8'h01, 32, 8'hE0);
    wr(1'b1, 1'b1, 32, 8'hE0, 8'hA0);
    drain(300, 1'b0, "tie misc-first drained");
    check("ovf still sticky", 32'(vid_ovf), 32'd1);

    // Reset mid-payload
    stream_ready = 1'b0;
    wr(1'b1, 1'b0, 32, 8'h50, 8'h00);
    tick();
    stream_ready = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h51);
    repeat (5) tick();
    stream_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("valid after mid-packet rst", 32'(stream_valid), 32'd0);
    check("ovf cleared by rst", 32'(vid_ovf), 32'd0);
    check("pre-reset bytes seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    stream_ready = 1'b1;
    early = 0;
    repeat (80) begin
      tick();
      if (stream_valid) early++;
    end
    check("fifo empty after rst", 32'(early), 32'd0);
    push_pkt(8'h01, 32, 8'h70);
    wr(1'b1, 1'b0, 32, 8'h70, 8'h00);
    drain(200, 1'b0, "post-reset packet drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
